testing_memory_arbiter: RTL and testbench
=========================================

TESTING_MEMORY_ARBITER -- requirements
Module: testing_memory_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the word-address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; byteenable width SHALL be DATA_W/8.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 mN_address  input  ADDR_W  requester N (N=0,1) word address.
REQ-006 mN_byteenable  input  DATA_W/8  requester N byte lanes for writes.
REQ-007 mN_read / mN_write  input  1  requester N read and write requests.
REQ-008 mN_writedata  input  DATA_W  requester N write data.
REQ-009 mN_waitrequest  output  1  high while requester N's request is not accepted this cycle.
REQ-010 mN_readdata  output  DATA_W  read data returned to requester N.
REQ-011 mN_readdatavalid  output  1  single-cycle qualifier for mN_readdata.
REQ-012 mem_address / mem_byteenable / mem_writedata  output  ADDR_W / DATA_W/8 / DATA_W  driven to the single-port RAM.
REQ-013 mem_chipselect / mem_write / mem_clken  output  1  RAM select, write enable and clock enable.
REQ-014 mem_readdata  input  DATA_W  RAM q output, valid one cycle after a read is issued.

Function
REQ-015 A requester SHALL be requesting when mN_read or mN_write is high; at most one request SHALL be granted per cycle.
REQ-016 Only one requester active: it SHALL be granted in the same cycle (mN_waitrequest low).
REQ-017 Both active: grant SHALL go to the requester not in the last_grant register (round-robin); the loser's waitrequest SHALL stay high.
REQ-018 last_grant SHALL update to the granted index on every granted cycle and hold when nothing is granted.
REQ-019 Memory outputs SHALL be combinational from the granted port: mem_chipselect=1, mem_write=granted write, address, byteenable and writedata muxed from the granted port.
REQ-020 No grant: mem_chipselect=0 and mem_write=0.
REQ-021 mN_read and mN_write both high on one port: the write SHALL be performed; the read SHALL be dropped with no readdatavalid.
REQ-022 An accepted read SHALL produce mN_readdatavalid high for exactly one cycle, one cycle after acceptance, with mN_readdata=mem_readdata in that cycle.
REQ-023 A registered read-return tag (valid bit and owner index) SHALL steer readdatavalid; back-to-back reads from alternating ports SHALL return in issue order, one per cycle.
REQ-024 mN_readdata SHALL be driven from mem_readdata to both ports; only readdatavalid SHALL be port-specific.
REQ-025 Writes SHALL produce no response beyond waitrequest deassertion.
REQ-026 A requester SHALL hold its request signals stable while waitrequest is high; the arbiter SHALL not latch unaccepted requests.
REQ-027 mem_clken SHALL be high whenever reset is low.

Reset
REQ-028 While reset is high: mN_waitrequest=1, mN_readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
REQ-029 Reset SHALL set last_grant=1, so requester 0 wins the first contention.
REQ-030 Reset asserted while a read is outstanding SHALL clear the return tag; that read's readdatavalid SHALL never appear.

Configuration
REQ-031 With macro ARB_FIXED_PRIORITY_EN defined, requester 0 SHALL always win contention and last_grant SHALL be unused.
REQ-032 Without ARB_FIXED_PRIORITY_EN, round-robin per REQ-017 SHALL apply.

Verification
REQ-033 After reset, m0 read addr 0x0010 alone -> m0_waitrequest=0 same cycle, m0_readdatavalid=1 next cycle with RAM word 0x0010.
REQ-034 m0 and m1 write 0xAAAA5555/0x12345678 to 0x0001/0x0002 in the same cycle -> m0 granted first, m1 next cycle; read-back returns both values.
REQ-035 Both ports reading continuously for 8 cycles -> grants alternate m0,m1,...; each readdatavalid pulse lands on the correct port one cycle after acceptance.
REQ-036 m1 writes 0xFFFFFFFF with byteenable 0x4 to a word holding 0 -> read-back is 0x00FF0000.
REQ-037 m0 read accepted, reset pulsed in the next cycle -> no readdatavalid; all outputs at REQ-028 values.
REQ-038 ARB_FIXED_PRIORITY_EN defined, both ports requesting for 4 cycles -> m0 granted all 4 cycles; m1_waitrequest stays high.

Source files
------------

// File: rtl/testing_memory_arbiter.sv
// testing_memory_arbiter
//
// Purpose:
//   Two-requester arbiter in front of one single-port synchronous RAM.
//   Each cycle at most one request is granted. The RAM signals are driven
//   combinationally from the granted port. A registered read-return tag
//   steers the RAM's one-cycle-late read data back to whichever port issued
//   the read.
//
// Handshake:
//   A port is requesting while mN_read or mN_write is high. The request is
//   accepted in the cycle mN_waitrequest is low at the rising clock edge.
//   While mN_waitrequest is high the requester keeps its request signals
//   stable. Nothing is latched for a request that has not been accepted.
//   An accepted read returns mN_readdatavalid for exactly one cycle, one
//   cycle after acceptance. An accepted write returns nothing further.
//
// Configuration:
//   ARB_FIXED_PRIORITY_EN - when defined, requester 0 always wins contention
//                           and no round-robin state is kept. When undefined
//                           (the default), contention alternates round-robin.
//
// Parameters:
//   ADDR_W - word-address width (default 14)
//   DATA_W - data width (default 32); byteenable width is DATA_W/8
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   mN_address/byteenable/read/write/writedata   requester N request (N=0,1)
//   mN_waitrequest          high while requester N's request is not accepted
//   mN_readdata             RAM read data (shared by both ports)
//   mN_readdatavalid        one-cycle qualifier for requester N's read data
//   mem_address/byteenable/writedata/chipselect/write/clken   RAM controls
//   mem_readdata            RAM q output, valid one cycle after a read

module testing_memory_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    logic req0;
    logic req1;
    logic gnt_valid;   // some port is granted this cycle
    logic gnt_idx;     // which port is granted (meaningful when gnt_valid)
    logic gnt_read;
    logic gnt_write;
    logic issue_read;  // granted read that actually reaches the RAM

    logic rtag_valid;  // a read was issued last cycle
    logic rtag_owner;  // port that issued it

`ifndef ARB_FIXED_PRIORITY_EN
    // Index of the most recently granted port; the other one wins the next
    // contention. Reset value 1 lets requester 0 win the first contention.
    logic last_grant;
`endif

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant selection. Nothing is granted while reset is high, which also
    // forces both waitrequests high and the RAM deselected.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt_valid = 1'b1;
`ifdef ARB_FIXED_PRIORITY_EN
                gnt_idx   = 1'b0;
`else
                gnt_idx   = ~last_grant;
`endif
            end else if (req0) begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b0;
            end else if (req1) begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b1;
            end
        end
    end

    assign gnt_read  = gnt_idx ? m1_read  : m0_read;
    assign gnt_write = gnt_idx ? m1_write : m0_write;

    // Read and write together on one port: the write wins and the read is
    // dropped, so no return tag is raised for it.
    assign issue_read = gnt_valid & gnt_read & ~gnt_write;

    assign mem_address    = gnt_idx ? m1_address    : m0_address;
    assign mem_byteenable = gnt_idx ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = gnt_idx ? m1_writedata  : m0_writedata;
    assign mem_chipselect = gnt_valid;
    assign mem_write      = gnt_valid & gnt_write;
    assign mem_clken      = ~reset;

    assign m0_waitrequest = ~(gnt_valid & ~gnt_idx);
    assign m1_waitrequest = ~(gnt_valid &  gnt_idx);

`ifndef ARB_FIXED_PRIORITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (gnt_valid) begin
            last_grant <= gnt_idx;
        end
    end
`endif

    // Return tag: the RAM answers one cycle after the read, so one stage of
    // tag is enough to keep alternating back-to-back reads in order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rtag_valid <= 1'b0;
            rtag_owner <= 1'b0;
        end else begin
            rtag_valid <= issue_read;
            rtag_owner <= gnt_idx;
        end
    end

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rtag_valid & ~rtag_owner;
    assign m1_readdatavalid = rtag_valid &  rtag_owner;

endmodule

// File: tb/tb_testing_memory_arbiter.sv
// Directed testbench for testing_memory_arbiter with a behavioural
// single-port RAM (registered q) attached to the memory port.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.

module tb_testing_memory_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = DW / 8;

`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, mem_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata, mem_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic          mem_chipselect, mem_write, mem_clken;

  testing_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_writedata    (mem_writedata),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // ---------------- RAM model ----------------
  logic [DW-1:0] ram [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // ---------------- scoreboard counters / check ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
  endtask

  task automatic drive(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Single uncontended write: accepted in the same cycle.
  task automatic single_write(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [BW-1:0] be, input bit chk);
    drive(p, 1'b0, 1'b1, a, d, be);
    @(negedge clk);
    if (chk) begin
      check("wr_wait", (p == 0) ? m0_waitrequest : m1_waitrequest, 0);
      check("wr_memwr", mem_write, 1);
    end
    next_cycle();
    idle_all();
  endtask

  // Single uncontended read; data checked one cycle after acceptance.
  task automatic single_read(input int p, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    drive(p, 1'b1, 1'b0, a, '0, '0);
    @(negedge clk);
    check("rd_wait", (p == 0) ? m0_waitrequest : m1_waitrequest, 0);
    check("rd_memaddr", mem_address, a);
    next_cycle();
    idle_all();
    @(negedge clk);
    check("rd_rdv_own", (p == 0) ? m0_readdatavalid : m1_readdatavalid, 1);
    check("rd_rdv_other", (p == 0) ? m1_readdatavalid : m0_readdatavalid, 0);
    check("rd_data", (p == 0) ? m0_readdata : m1_readdata, exp);
    next_cycle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] prev_data;
    int            g, prev_port;

    reset = 1'b1;
    idle_all();
    // Requests during reset must be ignored.
    m0_read = 1'b1;
    m1_write = 1'b1;
    @(negedge clk);
    check("rst_wait0", m0_waitrequest, 1);
    check("rst_wait1", m1_waitrequest, 1);
    check("rst_rdv0", m0_readdatavalid, 0);
    check("rst_rdv1", m1_readdatavalid, 0);
    check("rst_cs", mem_chipselect, 0);
    check("rst_memwr", mem_write, 0);
    check("rst_clken", mem_clken, 0);
    do_reset();

    @(negedge clk);
    check("idle_clken", mem_clken, 1);
    check("idle_cs", mem_chipselect, 0);
    next_cycle();

    // Preload RAM contents through the arbiter.
    single_write(0, 14'h0010, 32'hDEAD0010, 4'hF, 1'b1);
    single_write(1, 14'h0005, 32'h0000_0000, 4'hF, 1'b1);
    for (int k = 0; k < 8; k++) begin
      single_write(0, AW'(14'h0020 + k), 32'hA000_0000 | k, 4'hF, 1'b0);
      single_write(0, AW'(14'h0030 + k), 32'hB000_0000 | k, 4'hF, 1'b0);
    end

    // Lone read after reset.
    do_reset();
    single_read(0, 14'h0010, 32'hDEAD0010);
    @(negedge clk);
    check("rdv_one_cycle", m0_readdatavalid, 0);
    next_cycle();

    // Simultaneous writes: m0 first (both modes), m1 next cycle.
    do_reset();
    drive(0, 1'b0, 1'b1, 14'h0001, 32'hAAAA5555, 4'hF);
    drive(1, 1'b0, 1'b1, 14'h0002, 32'h12345678, 4'hF);
    @(negedge clk);
    check("cw_wait0", m0_waitrequest, 0);
    check("cw_wait1", m1_waitrequest, 1);
    check("cw_addr0", mem_address, 14'h0001);
    check("cw_wdata0", mem_writedata, 32'hAAAA5555);
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("cw_wait1_b", m1_waitrequest, 0);
    check("cw_addr1", mem_address, 14'h0002);
    check("cw_memwr1", mem_write, 1);
    next_cycle();
    idle_all();
    single_read(0, 14'h0001, 32'hAAAA5555);
    single_read(1, 14'h0002, 32'h12345678);

    // Continuous contention for 8 cycles.
    do_reset();
    a0 = 14'h0020;
    a1 = 14'h0030;
    prev_port = 0;
    prev_data = '0;
    drive(0, 1'b1, 1'b0, a0, '0, '0);
    drive(1, 1'b1, 1'b0, a1, '0, '0);
    for (int i = 0; i < 8; i++) begin
      g = FIXED ? 0 : (i % 2);
      @(negedge clk);
      check("cr_wait0", m0_waitrequest, (g != 0));
      check("cr_wait1", m1_waitrequest, (g != 1));
      check("cr_addr", mem_address, (g == 1) ? a1 : a0);
      if (i > 0) begin
        check("cr_rdv0", m0_readdatavalid, (prev_port == 0));
        check("cr_rdv1", m1_readdatavalid, (prev_port == 1));
        check("cr_data", (prev_port == 0) ? m0_readdata : m1_readdata, prev_data);
      end
      prev_port = g;
      prev_data = (g == 1) ? (32'hB000_0000 | 32'(a1 - 14'h0030))
                           : (32'hA000_0000 | 32'(a0 - 14'h0020));
      next_cycle();
      if (g == 0) a0 = a0 + 1'b1;
      else        a1 = a1 + 1'b1;
      drive(0, 1'b1, 1'b0, a0, '0, '0);
      drive(1, 1'b1, 1'b0, a1, '0, '0);
    end
    idle_all();
    @(negedge clk);
    check("cr_last_rdv0", m0_readdatavalid, (prev_port == 0));
    check("cr_last_rdv1", m1_readdatavalid, (prev_port == 1));
    check("cr_last_data", (prev_port == 0) ? m0_readdata : m1_readdata, prev_data);
    next_cycle();
    @(negedge clk);
    check("cr_quiet0", m0_readdatavalid, 0);
    check("cr_quiet1", m1_readdatavalid, 0);
    next_cycle();

    // Partial byte-enable write.
    single_write(1, 14'h0005, 32'hFFFFFFFF, 4'h4, 1'b1);
    single_read(1, 14'h0005, 32'h00FF0000);

    // Read and write together on one port: write done, read dropped.
    drive(0, 1'b1, 1'b1, 14'h0006, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    check("rw_memwr", mem_write, 1);
    check("rw_wait0", m0_waitrequest, 0);
    next_cycle();
    idle_all();
    @(negedge clk);
    check("rw_no_rdv", m0_readdatavalid, 0);
    next_cycle();
    single_read(0, 14'h0006, 32'h0BADF00D);

    // Reset while a read is outstanding.
    do_reset();
    drive(0, 1'b1, 1'b0, 14'h0010, '0, '0);
    @(negedge clk);
    check("rr_wait0", m0_waitrequest, 0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rr_wait0_rst", m0_waitrequest, 1);
    check("rr_wait1_rst", m1_waitrequest, 1);
    check("rr_rdv0_rst", m0_readdatavalid, 0);
    check("rr_rdv1_rst", m1_readdatavalid, 0);
    check("rr_cs_rst", mem_chipselect, 0);
    check("rr_memwr_rst", mem_write, 0);
    check("rr_clken_rst", mem_clken, 0);
    next_cycle();
    idle_all();
    reset = 1'b0;
    @(negedge clk);
    check("rr_rdv0_after", m0_readdatavalid, 0);
    check("rr_rdv1_after", m1_readdatavalid, 0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
